// File: rtl/nanosoc_busmatrix_input_hold_pkg.sv
// Shared AHB encodings, FSM state and address-phase control bundle
// for the bus-matrix input hold stage.
package nanosoc_busmatrix_input_hold_pkg;

  localparam logic [1:0] TRN_IDLE   = 2'b00;
  localparam logic [1:0] TRN_BUSY   = 2'b01;
  localparam logic [1:0] TRN_NONSEQ = 2'b10;
  localparam logic [1:0] TRN_SEQ    = 2'b11;

  localparam logic [2:0] BRST_SINGLE = 3'b000;
  localparam logic [2:0] BRST_INCR   = 3'b001;
  localparam logic [2:0] BRST_WRAP4  = 3'b010;
  localparam logic [2:0] BRST_INCR4  = 3'b011;
  localparam logic [2:0] BRST_WRAP8  = 3'b100;
  localparam logic [2:0] BRST_INCR8  = 3'b101;
  localparam logic [2:0] BRST_WRAP16 = 3'b110;
  localparam logic [2:0] BRST_INCR16 = 3'b111;

  localparam logic RSP_OKAY  = 1'b0;
  localparam logic RSP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PEND = 2'b01,
    DATA = 2'b10
  } hold_state_t;

  // Address-phase control fields; the address travels separately because
  // its width is a module parameter.
  typedef struct packed {
    logic       sel;
    logic [1:0] trans;
    logic       write;
    logic [2:0] size;
    logic [2:0] burst;
    logic [3:0] prot;
    logic       lock;
  } aphase_ctl_t;

  // NONSEQ and SEQ both carry bit 1; IDLE and BUSY never request a transfer.
  function automatic logic is_active_trans(input logic [1:0] trans);
    return trans[1];
  endfunction

endpackage

// File: rtl/nanosoc_busmatrix_addr_hold_reg.sv
// Load-enabled address-phase register with asynchronous clear.
module nanosoc_busmatrix_addr_hold_reg
  import nanosoc_busmatrix_input_hold_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  load,
  input  aphase_ctl_t           next_ctl,
  input  logic [ADDR_WIDTH-1:0] next_addr,
  output aphase_ctl_t           hold_ctl,
  output logic [ADDR_WIDTH-1:0] hold_addr
);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      hold_ctl  <= '0;
      hold_addr <= '0;
    end else if (load) begin
      hold_ctl  <= next_ctl;
      hold_addr <= next_addr;
    end
  end

endmodule

// File: rtl/nanosoc_busmatrix_input_hold.sv
// Bus-matrix input stage: forwards the master's address phase, holding it
// and inserting wait states while the addressed output is not granted.
module nanosoc_busmatrix_input_hold
  import nanosoc_busmatrix_input_hold_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSELS,
  input  logic [ADDR_WIDTH-1:0] HADDRS,
  input  logic [1:0]            HTRANSS,
  input  logic                  HWRITES,
  input  logic [2:0]            HSIZES,
  input  logic [2:0]            HBURSTS,
  input  logic [3:0]            HPROTS,
  input  logic                  HMASTLOCKS,
  input  logic                  HREADYS,
  input  logic                  active_in,
  input  logic                  HREADYOUTM,
  input  logic                  HRESPM,
  output logic                  HREADYOUTS,
  output logic                  HRESPS,
  output logic                  sel_out,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic [1:0]            trans_out,
  output logic                  write_out,
  output logic [2:0]            size_out,
  output logic [2:0]            burst_out,
  output logic [3:0]            prot_out,
  output logic                  lock_out,
  output logic                  held_tran
);

  hold_state_t           state;
  hold_state_t           state_nxt;
  aphase_ctl_t           live_ctl;
  aphase_ctl_t           hold_ctl;
  aphase_ctl_t           out_ctl;
  logic [ADDR_WIDTH-1:0] hold_addr;
  logic                  accept;
  logic                  taken;

  always_comb begin
    live_ctl       = '0;
    live_ctl.sel   = HSELS;
    live_ctl.trans = HTRANSS;
    live_ctl.write = HWRITES;
    live_ctl.size  = HSIZES;
    live_ctl.burst = HBURSTS;
    live_ctl.prot  = HPROTS;
    live_ctl.lock  = HMASTLOCKS;
  end

  // Captures every selected address phase the master completes, so the
  // register already holds the transfer when the FSM decides to stall it.
  nanosoc_busmatrix_addr_hold_reg #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_hold_reg (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .load      (HREADYS & HSELS),
    .next_ctl  (live_ctl),
    .next_addr (HADDRS),
    .hold_ctl  (hold_ctl),
    .hold_addr (hold_addr)
  );

  always_comb begin
    out_ctl  = held_tran ? hold_ctl  : live_ctl;
    addr_out = held_tran ? hold_addr : HADDRS;
  end

  assign sel_out   = out_ctl.sel;
  assign trans_out = out_ctl.trans;
  assign write_out = out_ctl.write;
  assign size_out  = out_ctl.size;
  assign burst_out = out_ctl.burst;
  assign prot_out  = out_ctl.prot;
  assign lock_out  = out_ctl.lock;

  assign accept = HSELS & HREADYS & is_active_trans(HTRANSS);
  assign taken  = sel_out & is_active_trans(trans_out) & active_in & HREADYOUTM;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = taken ? DATA : PEND;
        end
      end
      PEND: begin
        if (taken) begin
          state_nxt = DATA;
        end
      end
      DATA: begin
        // A stalled data phase keeps the new address phase out entirely.
        if (HREADYOUTM) begin
          if (accept) begin
            state_nxt = taken ? DATA : PEND;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    held_tran  = 1'b0;
    HREADYOUTS = 1'b1;
    HRESPS     = RSP_OKAY;
    case (state)
      PEND: begin
        held_tran  = 1'b1;
        HREADYOUTS = 1'b0;
      end
      DATA: begin
        HREADYOUTS = HREADYOUTM;
        HRESPS     = HRESPM;
      end
      default: begin
        held_tran  = 1'b0;
        HREADYOUTS = 1'b1;
        HRESPS     = RSP_OKAY;
      end
    endcase
  end

endmodule

// File: tb/tb_nanosoc_busmatrix_input_hold.sv
// Randomised and directed bench for the bus-matrix input hold stage.
module tb_nanosoc_busmatrix_input_hold;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSELS;
  logic [31:0] HADDRS;
  logic [1:0]  HTRANSS;
  logic        HWRITES;
  logic [2:0]  HSIZES;
  logic [2:0]  HBURSTS;
  logic [3:0]  HPROTS;
  logic        HMASTLOCKS;
  logic        HREADYS;
  logic        active_in;
  logic        HREADYOUTM;
  logic        HRESPM;
  logic        HREADYOUTS;
  logic        HRESPS;
  logic        sel_out;
  logic [31:0] addr_out;
  logic [1:0]  trans_out;
  logic        write_out;
  logic [2:0]  size_out;
  logic [2:0]  burst_out;
  logic [3:0]  prot_out;
  logic        lock_out;
  logic        held_tran;

  int n_chk = 0;
  int n_bad = 0;

  // Reference model: is a transfer waiting for grant, is a data phase open,
  // and the last captured address phase {sel,addr,trans,write,size,burst,prot,lock}.
  bit          m_pend;
  bit          m_data;
  logic [46:0] m_h;
  logic        e_ready;
  logic        e_resp;
  logic [46:0] e_fwd;
  logic        e_accept;
  logic        e_taken;

  nanosoc_busmatrix_input_hold #(.ADDR_WIDTH(32)) dut (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .HSELS      (HSELS),
    .HADDRS     (HADDRS),
    .HTRANSS    (HTRANSS),
    .HWRITES    (HWRITES),
    .HSIZES     (HSIZES),
    .HBURSTS    (HBURSTS),
    .HPROTS     (HPROTS),
    .HMASTLOCKS (HMASTLOCKS),
    .HREADYS    (HREADYS),
    .active_in  (active_in),
    .HREADYOUTM (HREADYOUTM),
    .HRESPM     (HRESPM),
    .HREADYOUTS (HREADYOUTS),
    .HRESPS     (HRESPS),
    .sel_out    (sel_out),
    .addr_out   (addr_out),
    .trans_out  (trans_out),
    .write_out  (write_out),
    .size_out   (size_out),
    .burst_out  (burst_out),
    .prot_out   (prot_out),
    .lock_out   (lock_out),
    .held_tran  (held_tran)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [46:0] live_vec();
    return {HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS};
  endfunction

  // Inputs already set by the caller; predict outputs, drive HREADYS as the
  // system would see it, let things settle and compare.
  task automatic drive_chk();
    logic [46:0] got_fwd;
    if (HRESET) begin
      m_pend = 1'b0;
      m_data = 1'b0;
      m_h    = '0;
    end
    e_ready  = m_pend ? 1'b0 : (m_data ? HREADYOUTM : 1'b1);
    e_resp   = m_data ? HRESPM : 1'b0;
    HREADYS  = e_ready;
    e_fwd    = m_pend ? m_h : live_vec();
    e_accept = HSELS & HREADYS & HTRANSS[1];
    e_taken  = e_fwd[46] & e_fwd[13] & active_in & HREADYOUTM;
    #2;
    got_fwd = {sel_out, addr_out, trans_out, write_out, size_out, burst_out, prot_out, lock_out};
    check("hreadyouts", 64'(HREADYOUTS), 64'(e_ready));
    check("hresps", 64'(HRESPS), 64'(e_resp));
    check("held_tran", 64'(held_tran), 64'(m_pend));
    check("fwd", 64'(got_fwd), 64'(e_fwd));
  endtask

  task automatic clk_upd();
    @(posedge HCLK);
    if (!HRESET) begin
      if (m_pend) begin
        if (e_taken) begin
          m_pend = 1'b0;
          m_data = 1'b1;
        end
      end else if (!m_data || HREADYOUTM) begin
        m_pend = e_accept & !e_taken;
        m_data = e_accept & e_taken;
      end
      if (HREADYS & HSELS) m_h = live_vec();
    end
    #1;
  endtask

  task automatic set_ap(input logic sel, input logic [31:0] addr, input logic [1:0] trans,
                        input logic wr, input logic [2:0] burst);
    HSELS      = sel;
    HADDRS     = addr;
    HTRANSS    = trans;
    HWRITES    = wr;
    HSIZES     = 3'b010;
    HBURSTS    = burst;
    HPROTS     = 4'b0011;
    HMASTLOCKS = 1'b0;
  endtask

  task automatic cyc();
    drive_chk();
    clk_upd();
  endtask

  initial begin
    HRESET = 1'b1; HREADYS = 1'b1; active_in = 1'b0; HREADYOUTM = 1'b1; HRESPM = 1'b0;
    set_ap(1'b0, 32'h0, 2'b00, 1'b0, 3'b000);
    cyc();
    cyc();
    HRESET = 1'b0;
    cyc();

    // Granted single write: forwarded live, no stall.
    active_in = 1'b1; HREADYOUTM = 1'b1;
    set_ap(1'b1, 32'h2000_0010, 2'b10, 1'b1, 3'b000);
    drive_chk();
    check("t1_addr", 64'(addr_out), 64'h2000_0010);
    check("t1_held", 64'(held_tran), 64'd0);
    clk_upd();
    set_ap(1'b1, 32'h0, 2'b00, 1'b0, 3'b000);
    drive_chk();
    check("t1_dready", 64'(HREADYOUTS), 64'd1);
    clk_upd();

    // Ungranted read: three wait states with the address held.
    active_in = 1'b0;
    set_ap(1'b1, 32'h3000_0000, 2'b10, 1'b0, 3'b000);
    cyc();
    for (int i = 0; i < 3; i++) begin
      active_in = (i == 2);
      HADDRS = 32'h5555_0000 + 32'(i);
      drive_chk();
      check("t2_held", 64'(held_tran), 64'd1);
      check("t2_ready", 64'(HREADYOUTS), 64'd0);
      check("t2_addr", 64'(addr_out), 64'h3000_0000);
      clk_upd();
    end
    set_ap(1'b1, 32'h0, 2'b00, 1'b0, 3'b000);
    drive_chk();
    check("t2_data_ready", 64'(HREADYOUTS), 64'd1);
    clk_upd();

    // Output wait states, then back to idle.
    active_in = 1'b1;
    set_ap(1'b1, 32'h4000_0000, 2'b10, 1'b1, 3'b000);
    cyc();
    set_ap(1'b1, 32'h0, 2'b00, 1'b0, 3'b000);
    for (int i = 0; i < 3; i++) begin
      HREADYOUTM = (i == 2);
      drive_chk();
      check("t3_ready", 64'(HREADYOUTS), 64'(i == 2));
      clk_upd();
    end
    HREADYOUTM = 1'b0;
    drive_chk();
    check("t3_idle_ready", 64'(HREADYOUTS), 64'd1);
    clk_upd();
    HREADYOUTM = 1'b1;

    // INCR4 with grant lost on beat 3.
    set_ap(1'b1, 32'h6000_0000, 2'b10, 1'b1, 3'b011);
    cyc();
    set_ap(1'b1, 32'h6000_0004, 2'b11, 1'b1, 3'b011);
    cyc();
    active_in = 1'b0;
    set_ap(1'b1, 32'h6000_0008, 2'b11, 1'b1, 3'b011);
    cyc();
    drive_chk();
    check("t4_addr", 64'(addr_out), 64'h6000_0008);
    check("t4_burst", 64'(burst_out), 64'd3);
    clk_upd();
    active_in = 1'b1;
    drive_chk();
    check("t4_regrant_held", 64'(held_tran), 64'd1);
    clk_upd();
    set_ap(1'b1, 32'h6000_000C, 2'b11, 1'b1, 3'b011);
    drive_chk();
    check("t4_beat4_addr", 64'(addr_out), 64'h6000_000C);
    clk_upd();
    set_ap(1'b1, 32'h0, 2'b00, 1'b0, 3'b000);
    cyc();

    // ERROR response passed through on both cycles.
    set_ap(1'b1, 32'h7000_0000, 2'b10, 1'b0, 3'b000);
    cyc();
    set_ap(1'b1, 32'h0, 2'b00, 1'b0, 3'b000);
    HRESPM = 1'b1; HREADYOUTM = 1'b0;
    drive_chk();
    check("t5_resp1", 64'(HRESPS), 64'd1);
    check("t5_ready1", 64'(HREADYOUTS), 64'd0);
    clk_upd();
    HREADYOUTM = 1'b1;
    drive_chk();
    check("t5_resp2", 64'(HRESPS), 64'd1);
    check("t5_ready2", 64'(HREADYOUTS), 64'd1);
    clk_upd();
    HRESPM = 1'b0;

    // Reset while pending discards the transfer at once.
    active_in = 1'b0;
    set_ap(1'b1, 32'h3100_0000, 2'b10, 1'b0, 3'b000);
    cyc();
    HRESET = 1'b1;
    drive_chk();
    check("t6_ready", 64'(HREADYOUTS), 64'd1);
    check("t6_held", 64'(held_tran), 64'd0);
    check("t6_resp", 64'(HRESPS), 64'd0);
    clk_upd();
    HRESET = 1'b0;
    active_in = 1'b1;
    set_ap(1'b1, 32'h2000_0010, 2'b10, 1'b1, 3'b000);
    drive_chk();
    check("t6_fresh_addr", 64'(addr_out), 64'h2000_0010);
    check("t6_fresh_held", 64'(held_tran), 64'd0);
    clk_upd();

    // Random traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      HRESET     = ($urandom_range(0, 199) == 0);
      HSELS      = ($urandom_range(0, 3) != 0);
      HADDRS     = $urandom;
      HTRANSS    = 2'($urandom_range(0, 3));
      HWRITES    = 1'($urandom);
      HSIZES     = 3'($urandom);
      HBURSTS    = 3'($urandom);
      HPROTS     = 4'($urandom);
      HMASTLOCKS = 1'($urandom);
      active_in  = ($urandom_range(0, 9) < 6);
      HREADYOUTM = ($urandom_range(0, 9) < 7);
      HRESPM     = ($urandom_range(0, 9) < 2);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
